// File: rtl/pacman_pkg.sv
// Shared types and the sprite overlap test for the Pac-Man game controller.
package pacman_pkg;

   localparam int SPRITE_SIZE = 8;
   localparam int COORD_W     = 10;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [2:0] {
      IDLE,
      PLAY,
      DYING,
      GAME_OVER,
      WIN
   } game_state_t;

   // Differences carry one extra bit so far-apart sprites never alias across the 10-bit wrap.
   function automatic logic overlap(coord_t ax, coord_t ay, coord_t bx, coord_t by);
      logic signed [COORD_W:0] dx;
      logic signed [COORD_W:0] dy;
      logic signed [COORD_W:0] lim;
      lim = (COORD_W+1)'(SPRITE_SIZE);
      dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
      dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      return (dx < lim) && (dy < lim);
   endfunction

endpackage

// File: rtl/pacman_game_ctrl_frame_tick_gen.sv
// Turns the asynchronous vertical-sync level into a one-Clk pulse per frame.
module frame_tick_gen (
   input  logic Clk,
   input  logic Reset_n,
   input  logic frame_clk,
   output logic frame_tick
);

   logic       sync0, sync1, prev, armed;
   logic [1:0] vld_pipe;

   // A rising edge only counts once a genuine low has come through the synchronizer.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync0      <= 1'b0;
         sync1      <= 1'b0;
         prev       <= 1'b0;
         armed      <= 1'b0;
         vld_pipe   <= '0;
         frame_tick <= 1'b0;
      end else begin
         sync0      <= frame_clk;
         sync1      <= sync0;
         prev       <= sync1;
         vld_pipe   <= {vld_pipe[0], 1'b1};
         armed      <= armed | (vld_pipe[1] & ~sync1);
         frame_tick <= sync1 & ~prev & armed;
      end
   end

endmodule

// File: rtl/pacman_game_ctrl.sv
// Pac-Man game controller: frame-driven state machine tracking lives,
// fruit pickups, score and the mouth animation.
module pacman_game_ctrl
   import pacman_pkg::*;
#(
   parameter int MOUTH_FRAMES = 8,
   parameter int DEATH_FRAMES = 60,
   parameter int START_LIVES  = 3
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    frame_clk,
   input  logic                    start,
   input  coord_t                  pacmanX,
   input  coord_t                  pacmanY,
   input  coord_t                  ghost_redX,
   input  coord_t                  ghost_redY,
   input  coord_t                  ghost_greenX,
   input  coord_t                  ghost_greenY,
   input  coord_t                  ghost_aquaX,
   input  coord_t                  ghost_aquaY,
   // Entry 2*i is fruit i X, entry 2*i+1 is its Y.
   input  logic [5:0][COORD_W-1:0] fruit_location,
   output logic                    death,
   output logic                    closePacman,
   output logic                    first_on,
   output logic                    second_on,
   output logic                    third_on,
   output logic                    isDefeated,
   output logic [1:0]              lives,
   output logic [7:0]              score
);

   localparam int MW = $clog2(MOUTH_FRAMES + 1);
   localparam int DW = $clog2(DEATH_FRAMES + 1);

   game_state_t   state, state_nx;
   logic          frame_tick;
   logic          start_s0, start_s1, start_prev, start_rise;
   logic [2:0]    fruit_on, fruit_hit, eat;
   logic          ghost_hit, last_eaten;
   logic [1:0]    eat_cnt;
   logic [8:0]    score_sum;
   logic [MW-1:0] mouth_cnt;
   logic [DW-1:0] death_cnt;

   frame_tick_gen u_tick (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .frame_clk  (frame_clk),
      .frame_tick (frame_tick)
   );

   assign first_on   = fruit_on[0];
   assign second_on  = fruit_on[1];
   assign third_on   = fruit_on[2];
   assign start_rise = start_s1 & ~start_prev;

   always_comb begin
      ghost_hit = overlap(pacmanX, pacmanY, ghost_redX,   ghost_redY)
                | overlap(pacmanX, pacmanY, ghost_greenX, ghost_greenY)
                | overlap(pacmanX, pacmanY, ghost_aquaX,  ghost_aquaY);
      fruit_hit[0] = overlap(pacmanX, pacmanY, fruit_location[0], fruit_location[1]);
      fruit_hit[1] = overlap(pacmanX, pacmanY, fruit_location[2], fruit_location[3]);
      fruit_hit[2] = overlap(pacmanX, pacmanY, fruit_location[4], fruit_location[5]);
      eat          = fruit_on & fruit_hit;
      eat_cnt      = {1'b0, eat[0]} + {1'b0, eat[1]} + {1'b0, eat[2]};
      score_sum    = {1'b0, score} + {7'd0, eat_cnt};
      last_eaten   = (eat != 3'b000) && ((fruit_on & ~eat) == 3'b000);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start_s1) state_nx = PLAY;
         PLAY:
            if (frame_tick) begin
               if (ghost_hit)       state_nx = (lives <= 2'd1) ? GAME_OVER : DYING;
               else if (last_eaten) state_nx = WIN;
            end
         DYING: if (frame_tick && death_cnt == DW'(DEATH_FRAMES - 1)) state_nx = PLAY;
         GAME_OVER, WIN: if (start_rise) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs and game data, all registered off the decided next state.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         start_s0    <= 1'b0;
         start_s1    <= 1'b0;
         start_prev  <= 1'b0;
         death       <= 1'b0;
         isDefeated  <= 1'b0;
         closePacman <= 1'b0;
         fruit_on    <= '0;
         lives       <= '0;
         score       <= '0;
         mouth_cnt   <= '0;
         death_cnt   <= '0;
      end else begin
         start_s0   <= start;
         start_s1   <= start_s0;
         start_prev <= start_s1;
         death      <= (state_nx == GAME_OVER);
         isDefeated <= (state_nx == WIN);
         case (state)
            IDLE:
               if (state_nx == PLAY) begin
                  lives       <= 2'(START_LIVES);
                  score       <= '0;
                  fruit_on    <= 3'b111;
                  mouth_cnt   <= '0;
                  closePacman <= 1'b0;
               end
            PLAY:
               if (frame_tick) begin
                  if (ghost_hit) begin
                     lives <= lives - 2'd1;
                  end else begin
                     fruit_on <= fruit_on & ~eat;
                     score    <= score_sum[8] ? 8'hFF : score_sum[7:0];
                  end
                  if (state_nx != PLAY) begin
                     mouth_cnt   <= '0;
                     closePacman <= 1'b0;
                  end else if (mouth_cnt == MW'(MOUTH_FRAMES - 1)) begin
                     mouth_cnt   <= '0;
                     closePacman <= ~closePacman;
                  end else begin
                     mouth_cnt <= mouth_cnt + MW'(1);
                  end
               end
            DYING:
               if (frame_tick) death_cnt <= (state_nx == PLAY) ? '0 : death_cnt + DW'(1);
            default: ;
         endcase
      end
   end

endmodule
